uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised successor to the existing fixed 8N1 receiver. Supports 5–9 data bits, none/odd/even parity and 1 or 2 stop bits, and uses 3-sample majority voting on a synchronised input. Received words go into an internal show-ahead FIFO, so the receiver never stalls waiting for the consumer. Sits between the host UART pin and the command decoder of the GPU front end.

Parameters:
CLK_FREQ, 106_666_666, system clock in Hz
BAUD_RATE, 1_000_000, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide), must be ≥ 8
DATA_BITS, 8, data bits per frame, 5..9, sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, FIFO entries, power of two, ≥ 2
SYNC_STAGES, 2, rx synchroniser flops, ≥ 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
rx  in  1  asynchronous serial line, idle high
rd_en  in  1  pop the FIFO head; ignored when rd_valid = 0
err_clear  in  1  clears the sticky overrun flag
rd_data  out  DATA_BITS  FIFO head word, valid while rd_valid = 1
rd_frame_err  out  1  head word had a bad stop bit
rd_parity_err  out  1  head word had a parity mismatch (always 0 when PARITY = 0)
rd_valid  out  1  FIFO not empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries
overrun  out  1  sticky: a frame was dropped because the FIFO was full
break_det  out  1  one-cycle pulse when a break condition is detected

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, FSM in WAIT_IDLE, synchroniser flops preset to 1. A reset mid-frame abandons the frame; nothing is pushed.
- Sampling: rx passes through SYNC_STAGES flops, giving rxs. Each bit is the majority of rxs at bit counts CLKS_PER_BIT-3, -2 and -1; the bit is decided at count CLKS_PER_BIT-1 and the counter then resets to 0.
- States and transitions:
  - WAIT_IDLE: go to IDLE when rxs = 1. Prevents a mid-frame resync after reset or a break.
  - IDLE: rxs = 0 → START, clear counter.
  - START: at count CLKS_HALF_BIT-1 (CLKS_PER_BIT/2), if rxs = 0 → DATA with bit index 0; else → IDLE (glitch rejected).
  - DATA: shift in DATA_BITS bits LSB first. After the last bit → PARITY if PARITY ≠ 0, else STOP.
  - PARITY: sample one bit. Parity error is set if the XOR of data and parity bit is 0 for odd parity, or 1 for even parity.
  - STOP: sample STOP_BITS bits. Frame error is set if any stop sample is 0. After the final stop bit decision, push {word, frame_err, parity_err} and go to IDLE in the same cycle.
- Break: the frame ends with word = 0, parity bit = 0 (if any) and first stop bit = 0. Then pulse break_det, do not push, and go to WAIT_IDLE.
- Latency: rd_valid and rd_data are updated on the clock edge following the push cycle.
- FIFO: show-ahead. rd_en with rd_valid = 1 advances the head on the next edge.
  - Push while full and no pop in the same cycle: the frame is dropped and overrun is set.
  - Push and pop in the same cycle while full: both succeed and fifo_count is unchanged.
  - Push and pop in the same cycle while empty: the word is pushed and the pop is ignored.
- Pointers wrap modulo FIFO_DEPTH; fifo_count saturates exactly at FIFO_DEPTH.
- overrun stays set until err_clear. If a set and err_clear occur in the same cycle, set wins.
- rd_frame_err and rd_parity_err are per-entry flags, not sticky.

Decomposition:
- Package uart_pkg holds PARITY_NONE/ODD/EVEN constants, the state encoding (WAIT_IDLE, IDLE, START, DATA, PARITY, STOP) and a clog2 helper.
- Sub-module sync_fifo: generic show-ahead FIFO with parameters WIDTH and DEPTH and ports wr_en, wr_data, rd_en, rd_data, empty, full, count.
- uart_rx_param instantiates sync_fifo with WIDTH = DATA_BITS+2.

Test Plan:
- 8N1 defaults (CLKS_PER_BIT = 106): send 0xA5 then 0x3C → rd_valid rises one cycle after each stop decision; pops return 0xA5 then 0x3C, both with error flags 0.
- DATA_BITS = 7, PARITY = 2 (even), STOP_BITS = 2: send 0x55 with correct parity bit 0 → no error; send 0x55 with parity bit 1 → rd_parity_err = 1, data 0x55.
- Stop bit forced to 0 on 0x81 → entry 0x81 with rd_frame_err = 1. Line held low for 2 frame times → one break_det pulse, no FIFO entry; no new frame accepted until rx returns high.
- FIFO_DEPTH = 4: send 5 frames with no pops → fifo_count = 4, overrun = 1, first 4 words intact. Pop on the cycle of a 6th push while full → count stays 4. err_clear → overrun = 0.
- Glitch: rx low for 20 clocks then high → no frame, FSM returns to IDLE. Deassert rst_n during bit 3 of a frame → no push; after reset release, a mid-frame low is ignored until rx is seen high.
- Majority voting: in each data bit, force one of the three sample clocks to the opposite level → 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, receiver state encoding and clog2 helper
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - generic show-ahead FIFO; head word is visible while not empty
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             rd_ok, wr_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with majority voting and receive FIFO
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 106_666_666,
  parameter int BAUD_RATE   = 1_000_000,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  input  logic                        rd_en,
  input  logic                        err_clear,
  output logic [DATA_BITS-1:0]        rd_data,
  output logic                        rd_frame_err,
  output logic                        rd_parity_err,
  output logic                        rd_valid,
  output logic [clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                        overrun,
  output logic                        break_det
);

  localparam int CLKS_PER_BIT  = CLK_FREQ / BAUD_RATE;
  localparam int CLKS_HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W         = clog2(CLKS_PER_BIT);
  localparam int BIT_W         = clog2(DATA_BITS);
  localparam int FIFO_W        = DATA_BITS + 2;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_SYNC  = CNT_W'(SYNC_STAGES);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  rx_state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             hist_q, hist_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_bit_q, par_bit_d;
  logic                   ferr_q, ferr_d;
  logic                   stop_idx_q, stop_idx_d;
  logic                   overrun_q, overrun_d;
  logic                   break_q, break_d;

  logic                   rxs, bit_maj, bit_end, data_xor, perr;
  logic                   push, rd_pop, fifo_empty, fifo_full;
  logic [FIFO_W-1:0]      push_word, head_word;

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], rx};
  // hist_q holds the samples from the two cycles before the deciding one.
  assign hist_d   = {hist_q[0], rxs};
  assign bit_maj  = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
  assign bit_end  = (cnt_q == CNT_LAST);
  assign data_xor = (^shift_q) ^ par_bit_q;
  assign perr     = (PARITY == PARITY_ODD)  ? ~data_xor :
                    (PARITY == PARITY_EVEN) ?  data_xor : 1'b0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    ferr_d     = ferr_q;
    stop_idx_d = stop_idx_q;
    break_d    = 1'b0;
    push       = 1'b0;
    push_word  = {shift_q, ferr_q | ~bit_maj, perr};
    unique case (state_q)
      ST_WAIT_IDLE: begin
        // The preset synchroniser must flush before rxs reflects the real line.
        if (cnt_q < CNT_SYNC) cnt_d = cnt_q + 1'b1;
        else if (rxs)         state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d     = '0;
          shift_d   = {bit_maj, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == BIT_LAST) begin
            state_d    = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            stop_idx_d = 1'b0;
            ferr_d     = 1'b0;
          end
        end
      end
      ST_PARITY: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d     = '0;
          par_bit_d = bit_maj;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          if (!stop_idx_q && (shift_q == '0) && !par_bit_q && !bit_maj) begin
            break_d = 1'b1;
            state_d = ST_WAIT_IDLE;
          end else if (stop_idx_q == STOP_LAST) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
            ferr_d     = ferr_q | ~bit_maj;
          end
        end
      end
      default: state_d = ST_WAIT_IDLE;
    endcase
  end

  assign rd_pop = rd_en && rd_valid;

  always_comb begin
    overrun_d = overrun_q;
    if (push && fifo_full && !rd_pop) overrun_d = 1'b1;
    else if (err_clear)               overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_WAIT_IDLE;
      sync_q     <= '1;
      hist_q     <= 2'b11;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      ferr_q     <= 1'b0;
      stop_idx_q <= 1'b0;
      overrun_q  <= 1'b0;
      break_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      hist_q     <= hist_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      ferr_q     <= ferr_d;
      stop_idx_q <= stop_idx_d;
      overrun_q  <= overrun_d;
      break_q    <= break_d;
    end
  end

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (push_word),
    .rd_en   (rd_en),
    .rd_data (head_word),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign rd_valid      = !fifo_empty;
  assign rd_data       = head_word[FIFO_W-1:2];
  assign rd_frame_err  = head_word[1];
  assign rd_parity_err = head_word[0];
  assign overrun       = overrun_q;
  assign break_det     = break_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for three receiver configurations
module tb_uart_rx_param;

  localparam int CPB = 106;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] rx_v, rd_en_v, clr_v;

  logic [7:0] rd_data_a, rd_data_c;
  logic [6:0] rd_data_b;
  logic [4:0] count_a, count_b;
  logic [2:0] count_c;
  logic fe_a, pe_a, valid_a, ovr_a, brk_a;
  logic fe_b, pe_b, valid_b, ovr_b, brk_b;
  logic fe_c, pe_c, valid_c, ovr_c, brk_c;

  uart_rx_param dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[0]), .rd_en(rd_en_v[0]), .err_clear(clr_v[0]),
    .rd_data(rd_data_a), .rd_frame_err(fe_a), .rd_parity_err(pe_a), .rd_valid(valid_a),
    .fifo_count(count_a), .overrun(ovr_a), .break_det(brk_a));

  uart_rx_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[1]), .rd_en(rd_en_v[1]), .err_clear(clr_v[1]),
    .rd_data(rd_data_b), .rd_frame_err(fe_b), .rd_parity_err(pe_b), .rd_valid(valid_b),
    .fifo_count(count_b), .overrun(ovr_b), .break_det(brk_b));

  uart_rx_param #(.FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[2]), .rd_en(rd_en_v[2]), .err_clear(clr_v[2]),
    .rd_data(rd_data_c), .rd_frame_err(fe_c), .rd_parity_err(pe_c), .rd_valid(valid_c),
    .fifo_count(count_c), .overrun(ovr_c), .break_det(brk_c));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_a = 0, rise_b = 0, brk_cnt_a = 0;
  logic pv_a = 1'b0, pv_b = 1'b0;
  logic [11:0] sb_a[$], sb_b[$], sb_c[$];
  logic [11:0] want;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    pv_a <= valid_a;
    pv_b <= valid_b;
    if (valid_a && !pv_a) rise_a <= cyc;
    if (valid_b && !pv_b) rise_b <= cyc;
    if (brk_a) brk_cnt_a <= brk_cnt_a + 1;
  end

  // Head of a DUT FIFO as {valid, data[8:0], frame_err, parity_err}.
  function automatic logic [11:0] head(input int sel);
    case (sel)
      0:       return {valid_a, 1'b0, rd_data_a, fe_a, pe_a};
      1:       return {valid_b, 2'b0, rd_data_b, fe_b, pe_b};
      default: return {valid_c, 1'b0, rd_data_c, fe_c, pe_c};
    endcase
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pop(input int sel);
    @(negedge clk);
    rd_en_v[sel] = 1'b1;
    @(negedge clk);
    rd_en_v[sel] = 1'b0;
  endtask

  task automatic send(input int sel, input logic [8:0] data, input int nbits, input int par,
                      input int nstop, input bit bad_par, input bit bad_stop, input bit glitch,
                      input int pop_at, input bit expect_push);
    logic frame[$];
    logic p, b;
    int   k;
    frame.push_back(1'b0);
    for (int i = 0; i < nbits; i++) frame.push_back(data[i]);
    if (par != 0) begin
      p = (par == 2) ? ^data : ~(^data);
      frame.push_back(p ^ bad_par);
    end
    frame.push_back(!bad_stop);
    if (nstop == 2) frame.push_back(1'b1);
    if (expect_push) begin
      case (sel)
        0:       sb_a.push_back({1'b1, data, bad_stop, bad_par});
        1:       sb_b.push_back({1'b1, data, bad_stop, bad_par});
        default: sb_c.push_back({1'b1, data, bad_stop, bad_par});
      endcase
    end
    for (int j = 0; j < frame.size() * CPB; j++) begin
      @(negedge clk);
      if (j == 0) start_cyc = cyc + 1;
      k = j / CPB;
      b = frame[k];
      if (glitch && k >= 1 && k <= nbits && (j % CPB) == 51 + ((k - 1) % 3)) b = ~b;
      rx_v[sel]    = b;
      rd_en_v[sel] = (j == pop_at);
    end
    @(negedge clk);
    rx_v[sel]    = 1'b1;
    rd_en_v[sel] = 1'b0;
    idle(10);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx_v = 3'b111; rd_en_v = 3'b000; clr_v = 3'b000;
    idle(5);
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid_a); end
    checks++; if (count_a !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", count_a); end
    checks++; if (ovr_a !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b want=0", ovr_a); end
    checks++; if (brk_a !== 1'b0) begin failures++; $display("FAIL reset_break got=%b want=0", brk_a); end
    checks++; if (rd_data_a !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", rd_data_a); end
    checks++; if (count_c !== 3'd0) begin failures++; $display("FAIL reset_count_c got=%0d want=0", count_c); end
    rst_n = 1'b1;
    idle(20);
  endtask

  task automatic test_8n1;
    logic [8:0] words [2];
    words[0] = 9'h0A5; words[1] = 9'h03C;
    for (int w = 0; w < 2; w++) begin
      send(0, words[w], 8, 0, 1, 0, 0, 0, -1, 1);
      checks++;
      if (rise_a - start_cyc !== 55 + CPB * 9) begin
        failures++; $display("FAIL latency_8n1 got=%0d want=%0d", rise_a - start_cyc, 55 + CPB * 9);
      end
      want = sb_a.pop_front();
      checks++; if (head(0) !== want) begin failures++; $display("FAIL data_8n1 got=%h want=%h", head(0), want); end
      pop(0);
    end
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL empty_8n1 got=%b want=0", valid_a); end
  endtask

  task automatic test_parity;
    send(1, 9'h055, 7, 2, 2, 0, 0, 0, -1, 1);
    checks++;
    if (rise_b - start_cyc !== 55 + CPB * 10) begin
      failures++; $display("FAIL latency_7e2 got=%0d want=%0d", rise_b - start_cyc, 55 + CPB * 10);
    end
    send(1, 9'h055, 7, 2, 2, 1, 0, 0, -1, 1);
    while (sb_b.size() > 0) begin
      want = sb_b.pop_front();
      checks++; if (head(1) !== want) begin failures++; $display("FAIL parity_7e2 got=%h want=%h", head(1), want); end
      pop(1);
    end
  endtask

  task automatic test_frame_err;
    send(0, 9'h081, 8, 0, 1, 0, 1, 0, -1, 1);
    idle(200);
    while (sb_a.size() > 0) begin
      want = sb_a.pop_front();
      checks++; if (head(0) !== want) begin failures++; $display("FAIL frame_err got=%h want=%h", head(0), want); end
      pop(0);
    end
  endtask

  task automatic test_break;
    int b0;
    b0 = brk_cnt_a;
    for (int j = 0; j < 2 * 10 * CPB; j++) begin
      @(negedge clk);
      rx_v[0] = 1'b0;
    end
    @(negedge clk);
    rx_v[0] = 1'b1;
    idle(50);
    checks++; if (brk_cnt_a - b0 !== 1) begin failures++; $display("FAIL break_pulses got=%0d want=1", brk_cnt_a - b0); end
    checks++; if (count_a !== 5'd0) begin failures++; $display("FAIL break_push got=%0d want=0", count_a); end
    send(0, 9'h042, 8, 0, 1, 0, 0, 0, -1, 1);
    want = sb_a.pop_front();
    checks++; if (head(0) !== want) begin failures++; $display("FAIL break_recover got=%h want=%h", head(0), want); end
    pop(0);
  endtask

  task automatic test_overrun;
    for (int i = 1; i <= 5; i++) send(2, 9'(i * 17), 8, 0, 1, 0, 0, 0, -1, i <= 4);
    checks++; if (count_c !== 3'd4) begin failures++; $display("FAIL ovr_count got=%0d want=4", count_c); end
    checks++; if (ovr_c !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b want=1", ovr_c); end
    want = sb_c.pop_front();
    checks++; if (head(2) !== want) begin failures++; $display("FAIL ovr_head got=%h want=%h", head(2), want); end
    send(2, 9'h066, 8, 0, 1, 0, 0, 0, 55 + CPB * 9, 1);
    checks++; if (count_c !== 3'd4) begin failures++; $display("FAIL full_pushpop got=%0d want=4", count_c); end
    @(negedge clk); clr_v[2] = 1'b1;
    @(negedge clk); clr_v[2] = 1'b0;
    checks++; if (ovr_c !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b want=0", ovr_c); end
    while (sb_c.size() > 0) begin
      want = sb_c.pop_front();
      checks++; if (head(2) !== want) begin failures++; $display("FAIL ovr_drain got=%h want=%h", head(2), want); end
      pop(2);
    end
    checks++; if (count_c !== 3'd0) begin failures++; $display("FAIL ovr_empty got=%0d want=0", count_c); end
  endtask

  task automatic test_glitch;
    int b0;
    b0 = brk_cnt_a;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      rx_v[0] = 1'b0;
    end
    @(negedge clk);
    rx_v[0] = 1'b1;
    idle(300);
    checks++; if (count_a !== 5'd0) begin failures++; $display("FAIL glitch_push got=%0d want=0", count_a); end
    checks++; if (brk_cnt_a !== b0) begin failures++; $display("FAIL glitch_break got=%0d want=%0d", brk_cnt_a, b0); end
    send(0, 9'h096, 8, 0, 1, 0, 0, 0, -1, 1);
    want = sb_a.pop_front();
    checks++; if (head(0) !== want) begin failures++; $display("FAIL glitch_recover got=%h want=%h", head(0), want); end
    pop(0);
  endtask

  task automatic test_reset_midframe;
    logic [4:0] pat;
    int b0;
    pat = 5'b00110;
    b0 = brk_cnt_a;
    for (int j = 0; j < 4 * CPB + 50; j++) begin
      @(negedge clk);
      rx_v[0] = pat[j / CPB];
    end
    rst_n = 1'b0;
    idle(4);
    rst_n = 1'b1;
    idle(400);
    rx_v[0] = 1'b1;
    idle(1500);
    checks++; if (count_a !== 5'd0) begin failures++; $display("FAIL rst_mid_push got=%0d want=0", count_a); end
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b want=0", valid_a); end
    checks++; if (brk_cnt_a !== b0) begin failures++; $display("FAIL rst_mid_break got=%0d want=%0d", brk_cnt_a, b0); end
    send(0, 9'h05A, 8, 0, 1, 0, 0, 0, -1, 1);
    want = sb_a.pop_front();
    checks++; if (head(0) !== want) begin failures++; $display("FAIL rst_mid_recover got=%h want=%h", head(0), want); end
    pop(0);
  endtask

  task automatic test_majority;
    send(0, 9'h0C3, 8, 0, 1, 0, 0, 1, -1, 1);
    want = sb_a.pop_front();
    checks++; if (head(0) !== want) begin failures++; $display("FAIL majority got=%h want=%h", head(0), want); end
    pop(0);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_frame_err();
    test_break();
    test_overrun();
    test_glitch();
    test_reset_midframe();
    test_majority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
